// File: rtl/write_buffer.sv
// write_buffer: store FIFO between dcache write port and axi_bridge.
// Forwards dcache reads, holding back any that collide with pending stores.
module write_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_WIDTH = 128,
    parameter int OFFSET_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_wr_req,
    input  logic [2:0]            c_wr_type,
    input  logic [31:0]           c_wr_addr,
    input  logic [3:0]            c_wr_wstrb,
    input  logic [LINE_WIDTH-1:0] c_wr_data,
    output logic                  c_wr_rdy,
    input  logic                  c_rd_req,
    input  logic [2:0]            c_rd_type,
    input  logic [31:0]           c_rd_addr,
    output logic                  c_rd_rdy,
    output logic                  b_wr_req,
    output logic [2:0]            b_wr_type,
    output logic [31:0]           b_wr_addr,
    output logic [3:0]            b_wr_wstrb,
    output logic [LINE_WIDTH-1:0] b_wr_data,
    input  logic                  b_wr_rdy,
    output logic                  b_rd_req,
    output logic [2:0]            b_rd_type,
    output logic [31:0]           b_rd_addr,
    input  logic                  b_rd_rdy,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0] TYPE_LINE = 3'd4;

    logic [2:0]            type_q  [DEPTH];
    logic [31:0]           addr_q  [DEPTH];
    logic [3:0]            wstrb_q [DEPTH];
    logic [LINE_WIDTH-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic push;
    logic pop;
    logic hit;
    logic blocked;

    assign c_wr_rdy = (count_q != FULL_CNT);
    assign push     = c_wr_req && c_wr_rdy;
    assign b_wr_req = (count_q != '0);
    assign pop      = b_wr_req && b_wr_rdy;
    assign empty    = (count_q == '0);

    assign b_wr_type  = type_q[head_q];
    assign b_wr_addr  = addr_q[head_q];
    assign b_wr_wstrb = wstrb_q[head_q];
    assign b_wr_data  = data_q[head_q];

    // Line-address hazard against held entries and the store entering now
    always_comb begin
        hit = push && (c_wr_addr[31:OFFSET_W] == c_rd_addr[31:OFFSET_W]);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] &&
                (addr_q[i][31:OFFSET_W] == c_rd_addr[31:OFFSET_W])) begin
                hit = 1'b1;
            end
        end
    end

    // Uncached reads also wait for every older store to drain (MMIO order)
    assign blocked = hit ||
                     ((c_rd_type != TYPE_LINE) && (!empty || push));

    assign b_rd_req  = c_rd_req && !blocked;
    assign c_rd_rdy  = b_rd_req && b_rd_rdy;
    assign b_rd_type = c_rd_type;
    assign b_rd_addr = c_rd_addr;

    // Pointers, occupancy and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload storage; contents only meaningful while valid
    always_ff @(posedge clk) begin
        if (push) begin
            type_q[tail_q]  <= c_wr_type;
            addr_q[tail_q]  <= c_wr_addr;
            wstrb_q[tail_q] <= c_wr_wstrb;
            data_q[tail_q]  <= c_wr_data;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed scenarios plus random traffic,
// checked against a queue-based model of the store buffer.
module tb_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_wr_req;
    logic [2:0]   c_wr_type;
    logic [31:0]  c_wr_addr;
    logic [3:0]   c_wr_wstrb;
    logic [127:0] c_wr_data;
    logic         c_wr_rdy;
    logic         c_rd_req;
    logic [2:0]   c_rd_type;
    logic [31:0]  c_rd_addr;
    logic         c_rd_rdy;
    logic         b_wr_req;
    logic [2:0]   b_wr_type;
    logic [31:0]  b_wr_addr;
    logic [3:0]   b_wr_wstrb;
    logic [127:0] b_wr_data;
    logic         b_wr_rdy;
    logic         b_rd_req;
    logic [2:0]   b_rd_type;
    logic [31:0]  b_rd_addr;
    logic         b_rd_rdy;
    logic         empty;

    write_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .c_wr_req   (c_wr_req),
        .c_wr_type  (c_wr_type),
        .c_wr_addr  (c_wr_addr),
        .c_wr_wstrb (c_wr_wstrb),
        .c_wr_data  (c_wr_data),
        .c_wr_rdy   (c_wr_rdy),
        .c_rd_req   (c_rd_req),
        .c_rd_type  (c_rd_type),
        .c_rd_addr  (c_rd_addr),
        .c_rd_rdy   (c_rd_rdy),
        .b_wr_req   (b_wr_req),
        .b_wr_type  (b_wr_type),
        .b_wr_addr  (b_wr_addr),
        .b_wr_wstrb (b_wr_wstrb),
        .b_wr_data  (b_wr_data),
        .b_wr_rdy   (b_wr_rdy),
        .b_rd_req   (b_rd_req),
        .b_rd_type  (b_rd_type),
        .b_rd_addr  (b_rd_addr),
        .b_rd_rdy   (b_rd_rdy),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   t;
        logic [31:0]  a;
        logic [3:0]   s;
        logic [127:0] d;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check, then advance model
    task automatic step(input logic wreq, input logic [2:0] wt,
                        input logic [31:0] wa, input logic [3:0] ws,
                        input logic [127:0] wd, input logic rreq,
                        input logic [2:0] rt, input logic [31:0] ra,
                        input logic wrdy, input logic rrdy,
                        input logic rst);
        logic full, push, pop, hit, blk, exp_brq;
        @(negedge clk);
        c_wr_req = wreq; c_wr_type = wt; c_wr_addr = wa;
        c_wr_wstrb = ws; c_wr_data = wd;
        c_rd_req = rreq; c_rd_type = rt; c_rd_addr = ra;
        b_wr_rdy = wrdy; b_rd_rdy = rrdy; reset = rst;
        #1;
        full = (q.size() == DEPTH);
        push = wreq && !full;
        pop  = (q.size() != 0) && wrdy;
        hit  = push && (wa[31:4] == ra[31:4]);
        foreach (q[i]) if (q[i].a[31:4] == ra[31:4]) hit = 1'b1;
        blk = hit || ((rt != 3'd4) && (q.size() != 0 || push));
        exp_brq = rreq && !blk;
        check("c_wr_rdy", 128'(c_wr_rdy), 128'(!full));
        check("b_wr_req", 128'(b_wr_req), 128'(q.size() != 0));
        check("empty", 128'(empty), 128'(q.size() == 0));
        check("b_rd_req", 128'(b_rd_req), 128'(exp_brq));
        check("c_rd_rdy", 128'(c_rd_rdy), 128'(exp_brq && rrdy));
        check("b_rd_addr", 128'(b_rd_addr), 128'(ra));
        check("b_rd_type", 128'(b_rd_type), 128'(rt));
        if (q.size() != 0) begin
            check("b_wr_type", 128'(b_wr_type), 128'(q[0].t));
            check("b_wr_addr", 128'(b_wr_addr), 128'(q[0].a));
            check("b_wr_wstrb", 128'(b_wr_wstrb), 128'(q[0].s));
            check("b_wr_data", b_wr_data, q[0].d);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{t: wt, a: wa, s: ws, d: wd});
        end
    endtask

    task automatic idle(input logic wrdy);
        step(1'b0, 3'd0, 32'h0, 4'h0, 128'h0, 1'b0, 3'd4,
             32'h0, wrdy, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d,
                      input logic wrdy);
        step(1'b1, 3'd4, a, 4'hf, d, 1'b0, 3'd4, 32'h0,
             wrdy, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [2:0] t, input logic [31:0] a,
                      input logic wrdy);
        step(1'b0, 3'd0, 32'h0, 4'h0, 128'h0, 1'b1, t, a,
             wrdy, 1'b1, 1'b0);
    endtask

    initial begin
        c_wr_req = 0; c_wr_type = 0; c_wr_addr = 0; c_wr_wstrb = 0;
        c_wr_data = 0; c_rd_req = 0; c_rd_type = 3'd4; c_rd_addr = 0;
        b_wr_rdy = 0; b_rd_rdy = 0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_c_wr_rdy", 128'(c_wr_rdy), 128'(1));
        check("rst_b_wr_req", 128'(b_wr_req), 128'(0));
        check("rst_b_rd_req", 128'(b_rd_req), 128'(0));
        check("rst_c_rd_rdy", 128'(c_rd_rdy), 128'(0));

        // 1: single line write presented the next cycle
        wr(32'h1c000100, 128'hdead_beef, 1'b0);
        #2;
        check("t1_b_wr_req", 128'(b_wr_req), 128'(1));
        check("t1_addr", 128'(b_wr_addr), 128'(32'h1c000100));
        check("t1_empty", 128'(empty), 128'(0));
        idle(1'b1);

        // 2: fill, reject fifth, then drain in order
        for (int i = 0; i < 5; i++)
            wr(32'h1c000200 + 32'(i * 16), 128'(i + 100), 1'b0);
        #2;
        check("t2_full", 128'(c_wr_rdy), 128'(0));
        check("t2_head", 128'(b_wr_addr), 128'(32'h1c000200));
        for (int i = 0; i < 4; i++) idle(1'b1);
        #2;
        check("t2_empty", 128'(empty), 128'(1));

        // 3: read to a pending line stalls until that entry pops
        wr(32'h00001230, 128'h3, 1'b0);
        rd(3'd4, 32'h00001238, 1'b0);
        #2;
        check("t3_blocked", 128'(b_rd_req), 128'(0));
        rd(3'd4, 32'h00001238, 1'b1);
        rd(3'd4, 32'h00001238, 1'b0);

        // 4: unrelated line passes straight through
        wr(32'h00001230, 128'h4, 1'b0);
        rd(3'd4, 32'h00002000, 1'b0);
        idle(1'b1);

        // 5: uncached read waits for full drain
        wr(32'h1c000400, 128'h5, 1'b0);
        rd(3'd2, 32'hbfaf8000, 1'b0);
        rd(3'd2, 32'hbfaf8000, 1'b1);
        rd(3'd2, 32'hbfaf8000, 1'b0);

        // 6: simultaneous push and pop at count 2, then reset
        wr(32'h1c000500, 128'h61, 1'b0);
        wr(32'h1c000510, 128'h62, 1'b0);
        wr(32'h1c000520, 128'h63, 1'b1);
        #2;
        check("t6_addr", 128'(b_wr_addr), 128'(32'h1c000510));
        step(1'b0, 3'd0, 32'h0, 4'h0, 128'h0, 1'b0, 3'd4, 32'h0,
             1'b0, 1'b0, 1'b1);
        #2;
        check("t6_rst_req", 128'(b_wr_req), 128'(0));
        check("t6_rst_empty", 128'(empty), 128'(1));

        // Random traffic over a small set of lines to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] wa, ra;
            wa = 32'h1c000000 | (32'($urandom_range(0, 7)) << 4)
                 | 32'($urandom_range(0, 15));
            ra = 32'h1c000000 | (32'($urandom_range(0, 7)) << 4)
                 | 32'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), wa,
                 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd4, ra,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
